// File: rtl/hack_mul_seq_pkg.sv
// Shared types and ALU control codes for the sequential Hack multiplier.
// The ALU is driven purely through the six Hack control bits below.
package hack_mul_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DBL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctl_t;

  localparam alu_ctl_t ALU_ZERO = 6'b101010;
  localparam alu_ctl_t ALU_ADD  = 6'b000010;
  localparam alu_ctl_t ALU_X    = 6'b001100;
  localparam alu_ctl_t ALU_Y    = 6'b110000;

endpackage

// File: rtl/hack_mul_seq_if.sv
// Request/response bundle for the sequential multiplier.
// The master issues start/a/b; the slave (the multiplier) returns status and result.
interface hack_mul_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             zr;
  logic             ng;

  modport master (
    output start, a, b,
    input  busy, done, product, zr, ng
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, zr, ng
  );
endinterface

// File: rtl/hack_mul_seq_alu.sv
// Combinational Hack ALU: optional zero/negate on each operand, add or AND,
// optional negate of the result, plus zero/negative flags.
module hack_mul_seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic             zr,
  output logic             ng,
  output logic [WIDTH-1:0] out
);
  logic [WIDTH-1:0] w_x0, w_x1, w_y0, w_y1, w_fn;

  always_comb begin
    w_x0 = zx ? '0 : x;
    w_x1 = nx ? ~w_x0 : w_x0;
    w_y0 = zy ? '0 : y;
    w_y1 = ny ? ~w_y0 : w_y0;
    w_fn = f ? (w_x1 + w_y1) : (w_x1 & w_y1);
    out  = no ? ~w_fn : w_fn;
    zr   = (out == '0);
    ng   = out[WIDTH-1];
  end
endmodule

// File: rtl/hack_mul_seq.sv
// Shift-and-add multiplier that time-shares one Hack ALU: ADD steps accumulate,
// DBL steps double the multiplicand, the controller shifts the multiplier.
module hack_mul_seq
  import hack_mul_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int EARLY_EXIT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  hack_mul_seq_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_acc, r_mcand, r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy, r_done, r_zr, r_ng;
  logic [WIDTH-1:0]   r_product;

  alu_ctl_t           w_alu_ctl;
  logic [WIDTH-1:0]   w_alu_x, w_alu_y, w_alu_out;
  logic               w_unused_zr, w_unused_ng;
  logic               w_accept, w_last, w_finish;

  hack_mul_seq_alu #(.WIDTH(WIDTH)) u_alu (
    .x   (w_alu_x),
    .y   (w_alu_y),
    .zx  (w_alu_ctl.zx),
    .nx  (w_alu_ctl.nx),
    .zy  (w_alu_ctl.zy),
    .ny  (w_alu_ctl.ny),
    .f   (w_alu_ctl.f),
    .no  (w_alu_ctl.no),
    .zr  (w_unused_zr),
    .ng  (w_unused_ng),
    .out (w_alu_out)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Last iteration: counter exhausted, or no multiplier bits remain after this shift
  always_comb begin
    w_last = (r_cnt == CNT_W'(WIDTH - 1)) ||
             ((EARLY_EXIT != 0) && ((r_mplier >> 1) == '0));
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_ADD;
      ST_ADD:  w_state_nxt = ST_DBL;
      ST_DBL:  w_state_nxt = w_last ? ST_DONE : ST_ADD;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / ALU steering logic
  always_comb begin
    w_alu_ctl = ALU_ZERO;
    w_alu_x   = r_acc;
    w_alu_y   = r_mcand;
    w_accept  = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      ST_IDLE: w_accept = bus.start;
      ST_ADD:  w_alu_ctl = ALU_ADD;
      ST_DBL: begin
        w_alu_ctl = ALU_ADD;
        w_alu_x   = r_mcand;
        w_finish  = w_last;
      end
      default: w_alu_ctl = ALU_ZERO;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) begin
        r_acc    <= '0;
        r_mcand  <= bus.a;
        r_mplier <= bus.b;
        r_cnt    <= '0;
      end
      if (r_state == ST_ADD && r_mplier[0]) r_acc <= w_alu_out;
      if (r_state == ST_DBL) begin
        r_mcand  <= w_alu_out;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
      end
    end
  end

  // Result is final once the last DBL completes, so publish it on entry to DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
      r_zr      <= 1'b1;
      r_ng      <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= w_finish;
      if (w_finish) begin
        r_product <= r_acc;
        r_zr      <= (r_acc == '0);
        r_ng      <= r_acc[WIDTH-1];
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;
  assign bus.zr      = r_zr;
  assign bus.ng      = r_ng;
endmodule
